// File: rtl/uart_fifo_pkg.sv
// Shared defaults and types for the UART receive FIFO and the host status register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_fifo_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_FIFO_WIDTH = 4;

    // Entry count for a given pointer width.
    function automatic int fifo_depth(input int width);
        return 1 << width;
    endfunction

    localparam int DEF_DEPTH = fifo_depth(DEF_FIFO_WIDTH);

    // Occupancy needs one extra bit so that a completely full FIFO (DEPTH) is representable.
    typedef logic [DEF_FIFO_WIDTH:0] fifo_count_t;

endpackage

// File: rtl/fifo_ram_2p.sv
// Storage array: one synchronous write port, one asynchronous read port, contents not reset.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the caller decides when a write is legal.
//
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module fifo_ram_2p #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is taken before the edge, so a same-edge write to the same slot returns the old entry.
    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Clocked receive FIFO between the UART receiver and the host read port, with flush and freeze.
// Latency: a push is poppable after one edge; Data_Out is updated on the edge that samples Pop_Data.
// Backpressure: none; a write into a full FIFO is dropped and flagged, a pop while empty is flagged.
//
// Ports: clk, rst (async active-high); Rx_Data/Data_Rdy write side; Pop_Data/Data_Out read side;
//        Flush, BIST_Mode control; FIFO_Empty/Full/Overflow/Underflow/Count status.
module uart_rx_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int FIFO_WIDTH  = DEF_FIFO_WIDTH,
    parameter int FULL_THRESH = 2**(FIFO_WIDTH-1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_BITS-1:0]  Rx_Data,
    input  logic                  Data_Rdy,
    input  logic                  Pop_Data,
    input  logic                  Flush,
    input  logic                  BIST_Mode,
    output logic                  FIFO_Empty,
    output logic                  FIFO_Full,
    output logic                  FIFO_Overflow,
    output logic                  FIFO_Underflow,
    output logic [FIFO_WIDTH:0]   FIFO_Count,
    output logic [DATA_BITS-1:0]  Data_Out
);

    localparam int CNT_W = FIFO_WIDTH + 1;
    localparam int DEPTH = fifo_depth(FIFO_WIDTH);

    localparam logic [CNT_W-1:0]      DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      THRESH_CNT = CNT_W'(FULL_THRESH);
    localparam logic [CNT_W-1:0]      CNT_ONE    = 1;
    localparam logic [FIFO_WIDTH-1:0] PTR_ONE    = 1;

    logic [FIFO_WIDTH-1:0] wp;
    logic [FIFO_WIDTH-1:0] rp;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [DATA_BITS-1:0]  rd_data;

    logic active;
    logic flush_en;
    logic is_empty;
    logic is_full;
    logic do_wr;
    logic do_rd;
    logic ovf_set;
    logic udf_set;

    // BIST freezes everything; Flush outranks normal traffic.
    assign active   = !BIST_Mode && !Flush;
    assign flush_en = !BIST_Mode && Flush;
    assign is_empty = (count == '0);
    assign is_full  = (count == DEPTH_CNT);

    // A pop at full frees a slot in the same edge, so push+pop at full is not an overflow.
    // Push+pop at empty only writes: there is no bypass from Rx_Data to Data_Out.
    assign do_rd   = active && Pop_Data && !is_empty;
    assign do_wr   = active && Data_Rdy && (!is_full || do_rd);
    assign ovf_set = active && Data_Rdy && !do_wr;
    assign udf_set = active && Pop_Data && is_empty;

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp             <= '0;
            rp             <= '0;
            count          <= '0;
            FIFO_Overflow  <= 1'b0;
            FIFO_Underflow <= 1'b0;
            Data_Out       <= '0;
        end else if (flush_en) begin
            wp             <= '0;
            rp             <= '0;
            count          <= '0;
            FIFO_Overflow  <= 1'b0;
            FIFO_Underflow <= 1'b0;
        end else begin
            count <= count_nxt;
            if (do_wr) begin
                wp <= wp + PTR_ONE;
            end
            if (do_rd) begin
                rp       <= rp + PTR_ONE;
                Data_Out <= rd_data;
            end
            if (do_rd) begin
                FIFO_Overflow <= 1'b0;
            end else if (ovf_set) begin
                FIFO_Overflow <= 1'b1;
            end
            if (udf_set) begin
                FIFO_Underflow <= 1'b1;
            end
        end
    end

    fifo_ram_2p #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (FIFO_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wp),
        .wdata (Rx_Data),
        .raddr (rp),
        .rdata (rd_data)
    );

    assign FIFO_Count = count;
    assign FIFO_Empty = is_empty;
    assign FIFO_Full  = (count >= THRESH_CNT);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo with a queue-based reference model.
// Latency: expected state for each driven cycle is checked just after the following rising edge.
// Backpressure: n/a.
module tb_uart_rx_fifo;

    localparam int DB    = 8;
    localparam int FW    = 2;
    localparam int DEPTH = 4;
    localparam int FT    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DB-1:0] Rx_Data = '0;
    logic          Data_Rdy = 1'b0;
    logic          Pop_Data = 1'b0;
    logic          Flush = 1'b0;
    logic          BIST_Mode = 1'b0;
    logic          FIFO_Empty;
    logic          FIFO_Full;
    logic          FIFO_Overflow;
    logic          FIFO_Underflow;
    logic [FW:0]   FIFO_Count;
    logic [DB-1:0] Data_Out;

    uart_rx_fifo #(
        .DATA_BITS   (DB),
        .FIFO_WIDTH  (FW),
        .FULL_THRESH (FT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Rx_Data        (Rx_Data),
        .Data_Rdy       (Data_Rdy),
        .Pop_Data       (Pop_Data),
        .Flush          (Flush),
        .BIST_Mode      (BIST_Mode),
        .FIFO_Empty     (FIFO_Empty),
        .FIFO_Full      (FIFO_Full),
        .FIFO_Overflow  (FIFO_Overflow),
        .FIFO_Underflow (FIFO_Underflow),
        .FIFO_Count     (FIFO_Count),
        .Data_Out       (Data_Out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cnt;
        bit            empty;
        bit            full;
        bit            ovf;
        bit            udf;
        logic [DB-1:0] dout;
    } exp_t;

    exp_t          exp_q[$];
    logic [DB-1:0] mq[$];
    bit            m_ovf;
    bit            m_udf;
    logic [DB-1:0] m_dout;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic check_state(input string tag, input exp_t e);
        chk({tag, " count"},     32'(FIFO_Count),     32'(e.cnt));
        chk({tag, " empty"},     32'(FIFO_Empty),     32'(e.empty));
        chk({tag, " full"},      32'(FIFO_Full),      32'(e.full));
        chk({tag, " overflow"},  32'(FIFO_Overflow),  32'(e.ovf));
        chk({tag, " underflow"}, 32'(FIFO_Underflow), 32'(e.udf));
        chk({tag, " data_out"},  32'(Data_Out),       32'(e.dout));
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.cnt   = mq.size();
        e.empty = (mq.size() == 0);
        e.full  = (mq.size() >= FT);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        e.dout  = m_dout;
        return e;
    endfunction

    function automatic exp_t reset_state();
        exp_t e;
        e.cnt   = 0;
        e.empty = 1'b1;
        e.full  = 1'b0;
        e.ovf   = 1'b0;
        e.udf   = 1'b0;
        e.dout  = '0;
        return e;
    endfunction

    // One clock of stimulus; the model applies the behavioural rules and queues the expected result.
    task automatic step(input bit dr, input logic [DB-1:0] d, input bit pp, input bit fl, input bit bm);
        int pre;
        @(negedge clk);
        Data_Rdy  = dr;
        Rx_Data   = d;
        Pop_Data  = pp;
        Flush     = fl;
        BIST_Mode = bm;
        if (bm) begin
            // frozen: nothing changes
        end else if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            pre = mq.size();
            if (pp) begin
                if (pre > 0) begin
                    m_dout = mq.pop_front();
                    m_ovf  = 1'b0;
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (dr) begin
                if (pre < DEPTH || (pp && pre > 0)) mq.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        exp_q.push_back(model_snapshot());
    endtask

    task automatic push(input logic [DB-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset away from any clock edge; outputs must change before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        Data_Rdy  = 1'b0;
        Pop_Data  = 1'b0;
        Flush     = 1'b0;
        BIST_Mode = 1'b0;
        #2 rst = 1'b1;
        #1 check_state(tag, reset_state());
        mq.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares the DUT against the oldest queued expectation after each rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_state("cycle", e);
            end
        end
    end

    initial begin : stimulus
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;

        #2 rst = 1'b1;
        #1 check_state("reset", reset_state());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        idle();

        // Fill then drain in order.
        for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
        for (int i = 0; i < 4; i++) pop();

        // Overflow, then a pop clears it.
        for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
        push(8'hEE);
        pop();

        // Back to full, then push+pop at full repeatedly to wrap the pointers.
        push(8'hB0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'h55 + 8'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) pop();

        // Underflow, push+pop at empty, then flush (with requests that must be ignored).
        pop();
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);

        // Freeze with two entries held.
        push(8'hC1);
        push(8'hC2);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h33, 1'b1, 1'b1, 1'b1);
        pop();
        pop();

        // Reset mid-stream at count 3.
        push(8'hD1);
        push(8'hD2);
        push(8'hD3);
        async_reset("midreset");
        idle();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 11) == 0));
        end
        for (int i = 0; i < 6; i++) pop();

        @(posedge clk);
        #3;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
